// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    localparam int OVS       = 16;
    localparam int MID_TICK  = 7;
    localparam int LAST_TICK = 15;

    // Tick counter must hold both LAST_TICK and SB_TICK-1.
    function automatic int tick_width(input int sb_tick);
        return ($clog2(sb_tick) > $clog2(OVS)) ? $clog2(sb_tick) : $clog2(OVS);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Serial-side inputs and word-side outputs of the UART receiver.
interface uart_receiver_if;

    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    modport master (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done_tick,
        input  frame_err
    );

    modport slave (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done_tick,
        output frame_err
    );

endinterface

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampling, start/data/stop framing, registered word,
// done pulse and framing-error flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_receiver_if.slave  rx_bus
);

    localparam int SW = tick_width(SB_TICK);

    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    logic           rx_s;
    uart_rx_state_t state_q;
    logic [SW-1:0]  s_q;
    logic [2:0]     n_q;
    logic [7:0]     b_q;
    logic [7:0]     dout_q;
    logic           done_q;
    logic           ferr_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_bus.rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // Leaving idle does not wait for a tick, so a falling edge right
                // after a stop bit is caught on the very next clock.
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (rx_bus.s_tick) begin
                        if (s_q == S_MID) begin
                            if (!rx_s) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + S_ONE;
                        end
                    end
                end
                DATA: begin
                    if (rx_bus.s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q <= '0;
                            b_q <= {rx_s, b_q[7:1]};
                            if (n_q == N_LAST) begin
                                state_q <= STOP;
                            end else begin
                                n_q <= n_q + 3'd1;
                            end
                        end else begin
                            s_q <= s_q + S_ONE;
                        end
                    end
                end
                STOP: begin
                    if (rx_bus.s_tick) begin
                        if (s_q == S_STOP) begin
                            // Short words arrive MSB-aligned in b_q; shift them down.
                            ferr_q  <= ~rx_s;
                            dout_q  <= b_q >> (8 - DBIT);
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            s_q <= s_q + S_ONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_bus.dout         = dout_q;
    assign rx_bus.rx_done_tick = done_q;
    assign rx_bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8N1 instance plus a 7-bit / 2-stop instance.
module tb_uart_receiver;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } exp_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic s_tick = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q1[$];
    exp_t q2[$];
    int   pulses1   = 0;
    int   pulses2   = 0;
    int   last_cyc1 = 0;
    int   last_cyc2 = 0;
    logic prev1     = 1'b0;
    logic prev2     = 1'b0;
    int   start_cyc = 0;

    uart_receiver_if if1();
    uart_receiver_if if2();

    assign if1.s_tick = s_tick;
    assign if2.s_tick = s_tick;

    uart_receiver #(.DBIT(8), .SB_TICK(16)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (if1)
    );

    uart_receiver #(.DBIT(7), .SB_TICK(32)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (if2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // One oversampling tick every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Output monitors: every pulse pops one expected word from its scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if1.rx_done_tick === 1'b1) begin
                total++;
                assert (prev1 === 1'b0) else begin
                    bad++;
                    $error("FAIL pulse_width1 observed=%b expected=0", prev1);
                end
                total++;
                assert ((q1.size() != 0) === 1'b1) else begin
                    bad++;
                    $error("FAIL spurious1 observed dout=%h expected no pulse", if1.dout);
                end
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    total++;
                    assert ({if1.dout, if1.frame_err} === {e.d, e.fe}) else begin
                        bad++;
                        $error("FAIL word1 observed dout=%h ferr=%b expected dout=%h ferr=%b",
                               if1.dout, if1.frame_err, e.d, e.fe);
                    end
                    $display("dut1 word dout=%h ferr=%b at cyc=%0d", if1.dout, if1.frame_err, cyc);
                end
                pulses1++;
                last_cyc1 = cyc;
            end
            if (if2.rx_done_tick === 1'b1) begin
                total++;
                assert (prev2 === 1'b0) else begin
                    bad++;
                    $error("FAIL pulse_width2 observed=%b expected=0", prev2);
                end
                total++;
                assert ((q2.size() != 0) === 1'b1) else begin
                    bad++;
                    $error("FAIL spurious2 observed dout=%h expected no pulse", if2.dout);
                end
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    total++;
                    assert ({if2.dout, if2.frame_err} === {e.d, e.fe}) else begin
                        bad++;
                        $error("FAIL word2 observed dout=%h ferr=%b expected dout=%h ferr=%b",
                               if2.dout, if2.frame_err, e.d, e.fe);
                    end
                    $display("dut2 word dout=%h ferr=%b at cyc=%0d", if2.dout, if2.frame_err, cyc);
                end
                pulses2++;
                last_cyc2 = cyc;
            end
            prev1 = if1.rx_done_tick;
            prev2 = if2.rx_done_tick;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (s_tick !== 1'b1);
        end
    endtask

    task automatic drive_rx(input int which, input logic v);
        #1;
        if (which == 1) if1.rx = v;
        else            if2.rx = v;
    endtask

    // A bad stop bit is held low only across its mid-point sample so the
    // trailing low does not look like a full new start bit.
    task automatic send_frame(input int which, input logic [7:0] data, input int nbits,
                              input logic stop_ok, input int stop_ticks);
        logic [7:0] all_ones;
        exp_t       e;
        all_ones = 8'hFF;
        e.d  = data & (all_ones >> (8 - nbits));
        e.fe = ~stop_ok;
        if (which == 1) q1.push_back(e);
        else            q2.push_back(e);
        drive_rx(which, 1'b0);
        start_cyc = cyc;
        wait_ticks(OVS);
        for (int i = 0; i < nbits; i++) begin
            drive_rx(which, data[i]);
            wait_ticks(OVS);
        end
        if (stop_ok) begin
            drive_rx(which, 1'b1);
            wait_ticks(stop_ticks);
        end else begin
            drive_rx(which, 1'b0);
            wait_ticks(10);
            drive_rx(which, 1'b1);
            wait_ticks(stop_ticks - 10);
        end
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while ((q1.size() + q2.size()) != 0 && i < 2000) begin
            @(posedge clk);
            i++;
        end
        total++;
        assert ((q1.size() + q2.size()) === 0) else begin
            bad++;
            $error("FAIL %s observed pending=%0d expected 0", tag, q1.size() + q2.size());
        end
    endtask

    initial begin
        int saved;
        int lat;
        if1.rx = 1'b1;
        if2.rx = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        total++;
        assert ({if1.dout, if1.rx_done_tick, if1.frame_err} === 10'h000) else begin
            bad++;
            $error("FAIL reset1 observed=%h expected=000", {if1.dout, if1.rx_done_tick, if1.frame_err});
        end
        total++;
        assert ({if2.dout, if2.rx_done_tick, if2.frame_err} === 10'h000) else begin
            bad++;
            $error("FAIL reset2 observed=%h expected=000", {if2.dout, if2.rx_done_tick, if2.frame_err});
        end
        reset = 1'b0;
        wait_ticks(20);

        // 1: basic frame and latency
        send_frame(1, 8'hA5, 8, 1'b1, 16);
        drain("drain_a5");
        lat = last_cyc1 - start_cyc;
        total++;
        assert ((lat >= 604 && lat <= 612) === 1'b1) else begin
            bad++;
            $error("FAIL latency_a5 observed=%0d expected=604..612", lat);
        end
        wait_ticks(8);

        // 2: start glitch, then a good frame
        saved = pulses1;
        drive_rx(1, 1'b0);
        wait_ticks(4);
        drive_rx(1, 1'b1);
        wait_ticks(24);
        total++;
        assert (pulses1 === saved) else begin
            bad++;
            $error("FAIL glitch_pulse observed=%0d expected=%0d", pulses1, saved);
        end
        total++;
        assert (dut1.state_q === IDLE) else begin
            bad++;
            $error("FAIL glitch_idle observed=%0d expected=%0d", dut1.state_q, IDLE);
        end
        send_frame(1, 8'h3C, 8, 1'b1, 16);
        drain("drain_3c");
        wait_ticks(8);

        // 3: framing error delivered and held, cleared by next good frame
        send_frame(1, 8'h81, 8, 1'b0, 16);
        drain("drain_81");
        wait_ticks(20);
        total++;
        assert (if1.frame_err === 1'b1) else begin
            bad++;
            $error("FAIL ferr_hold observed=%b expected=1", if1.frame_err);
        end
        send_frame(1, 8'h00, 8, 1'b1, 16);

        // 4: back-to-back frames without idle gap
        send_frame(1, 8'h00, 8, 1'b1, 16);
        send_frame(1, 8'hFF, 8, 1'b1, 16);
        send_frame(1, 8'h55, 8, 1'b1, 16);
        drain("drain_b2b");
        wait_ticks(8);

        // 5: reset during data bit 4 of 0xF0
        saved = pulses1;
        drive_rx(1, 1'b0);
        wait_ticks(OVS);
        for (int i = 0; i < 4; i++) begin
            drive_rx(1, 1'b0);
            wait_ticks(OVS);
        end
        drive_rx(1, 1'b1);
        wait_ticks(8);
        #1 reset = 1'b1;
        #1;
        total++;
        assert ({if1.dout, if1.rx_done_tick, if1.frame_err} === 10'h000) else begin
            bad++;
            $error("FAIL midreset observed=%h expected=000", {if1.dout, if1.rx_done_tick, if1.frame_err});
        end
        if1.rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_ticks(200);
        total++;
        assert (pulses1 === saved) else begin
            bad++;
            $error("FAIL midreset_pulse observed=%0d expected=%0d", pulses1, saved);
        end
        total++;
        assert (dut1.state_q === IDLE) else begin
            bad++;
            $error("FAIL midreset_idle observed=%0d expected=%0d", dut1.state_q, IDLE);
        end
        send_frame(1, 8'h12, 8, 1'b1, 16);
        drain("drain_12");

        // 6: 7 data bits, 2 stop bits
        send_frame(2, 8'h5A, 7, 1'b1, 32);
        drain("drain_5a");
        lat = last_cyc2 - start_cyc;
        total++;
        assert ((lat >= 604 && lat <= 612) === 1'b1) else begin
            bad++;
            $error("FAIL latency_5a observed=%0d expected=604..612", lat);
        end
        total++;
        assert (if2.dout[7] === 1'b0) else begin
            bad++;
            $error("FAIL dout2_msb observed=%b expected=0", if2.dout[7]);
        end

        wait_ticks(16);
        total++;
        assert ({pulses1, pulses2} === {32'd8, 32'd1}) else begin
            bad++;
            $error("FAIL pulse_count observed=%0d/%0d expected=8/1", pulses1, pulses2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
